tl_tx_vc_data_buffer: RTL and testbench

Transmit-side per-VC payload buffer for one TLP class: P, NP or CPL. The AXI-side TLP builder writes payload as 8-DW lines. Each TLP's lines stay hidden until the TLP is committed, and an aborted TLP is rolled back. The TX arbiter then starts a transfer of N lines, which are streamed to the DLL-facing mux over a valid/ready interface with a registered output stage. Free-space reporting feeds the TX flow-control gate.

---
 rtl/tl_tx_vc_data_buffer.sv | 94 +++++++++
 tb/tb_tl_tx_vc_data_buffer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/tl_tx_vc_data_buffer.sv
// tl_tx_vc_data_buffer: per-VC TX payload FIFO with commit/abort on the write side
// and a registered valid/ready line stream for N-line transfers on the read side.
module tl_tx_vc_data_buffer #(
  parameter int DW              = 32,
  parameter int DATA_FIFO_DEPTH = 256,
  parameter int DATA_PTR_SIZE   = $clog2(DATA_FIFO_DEPTH) + 1,
  parameter int BUFFER_WIDTH    = 8 * DW,
  parameter int LEN_WIDTH       = 8
) (
  input  logic                     i_clk,
  input  logic                     i_n_rst,
  input  logic                     i_w_data_en,
  input  logic [BUFFER_WIDTH-1:0]  i_w_tlp_data,
  input  logic                     i_w_commit,
  input  logic                     i_w_abort,
  output logic                     o_w_full,
  output logic [DATA_PTR_SIZE-1:0] o_w_free_lines,
  input  logic                     i_r_start,
  input  logic [LEN_WIDTH-1:0]     i_r_lines,
  output logic                     o_r_busy,
  output logic                     o_r_empty,
  output logic                     o_r_valid,
  output logic [BUFFER_WIDTH-1:0]  o_r_data,
  output logic                     o_r_last,
  input  logic                     i_r_ready
);
  localparam int AW = DATA_PTR_SIZE - 1;
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state, state_n;
  logic [BUFFER_WIDTH-1:0]  mem [DATA_FIFO_DEPTH];
  logic [DATA_PTR_SIZE-1:0] w_cntr, w_commit, r_ptr, r_ptr_n, used, w_cntr_inc;
  logic [LEN_WIDTH-1:0]     remaining, remaining_n;
  logic [BUFFER_WIDTH-1:0]  data_n;
  logic                     wr_ok, fetch, accept, valid_n, last_n;
  assign used           = w_cntr - r_ptr;
  assign o_w_full       = used == DATA_PTR_SIZE'(DATA_FIFO_DEPTH);
  assign o_w_free_lines = DATA_PTR_SIZE'(DATA_FIFO_DEPTH) - used;
  assign o_r_empty      = r_ptr == w_commit;
  assign o_r_busy       = state == ACTIVE;
  // abort wins over a same-cycle write, so the line is never stored
  assign wr_ok          = i_w_data_en & ~o_w_full & ~i_w_abort;
  assign w_cntr_inc     = w_cntr + DATA_PTR_SIZE'(wr_ok);
  assign accept         = o_r_valid & i_r_ready;
  assign fetch          = o_r_busy & (remaining != '0) & ~o_r_empty & (~o_r_valid | i_r_ready);
  always_ff @(posedge i_clk)
    if (wr_ok) mem[w_cntr[AW-1:0]] <= i_w_tlp_data;
  always_ff @(posedge i_clk or negedge i_n_rst)
    if (!i_n_rst) begin
      w_cntr   <= '0;
      w_commit <= '0;
    end else begin
      w_cntr   <= i_w_abort ? w_commit : w_cntr_inc;
      w_commit <= (!i_w_abort && i_w_commit) ? w_cntr_inc : w_commit;
    end
  always_comb begin
    state_n     = state;
    remaining_n = remaining;
    r_ptr_n     = r_ptr;
    valid_n     = o_r_valid;
    last_n      = o_r_last;
    data_n      = o_r_data;
    if (state == IDLE && i_r_start && i_r_lines != '0) begin
      state_n     = ACTIVE;
      remaining_n = i_r_lines;
    end
    if (fetch) begin
      data_n      = mem[r_ptr[AW-1:0]];
      valid_n     = 1'b1;
      last_n      = remaining == LEN_WIDTH'(1);
      r_ptr_n     = r_ptr + DATA_PTR_SIZE'(1);
      remaining_n = remaining - LEN_WIDTH'(1);
    end else if (accept) begin
      valid_n = 1'b0;
      state_n = o_r_last ? IDLE : state;
      last_n  = 1'b0;
    end
  end
  always_ff @(posedge i_clk or negedge i_n_rst)
    if (!i_n_rst) begin
      state     <= IDLE;
      remaining <= '0;
      r_ptr     <= '0;
      o_r_valid <= 1'b0;
      o_r_last  <= 1'b0;
      o_r_data  <= '0;
    end else begin
      state     <= state_n;
      remaining <= remaining_n;
      r_ptr     <= r_ptr_n;
      o_r_valid <= valid_n;
      o_r_last  <= last_n;
      o_r_data  <= data_n;
    end
endmodule

// File: tb/tb_tl_tx_vc_data_buffer.sv
// tb_tl_tx_vc_data_buffer: directed and randomized checks of the TX VC data buffer
// against a queue-based model of committed/pending lines and the output register.
module tb_tl_tx_vc_data_buffer;
  logic         clk = 0, rst_n = 0;
  logic         wen = 0, commit = 0, abort = 0, start = 0, ready = 1;
  logic [255:0] wdata = '0;
  logic [7:0]   lines = '0;
  logic         full, busy, empty, valid, last;
  logic [8:0]   free;
  logic [255:0] rdata;
  int vectors = 0, miscompares = 0;
  bit tog = 0;

  tl_tx_vc_data_buffer dut (
    .i_clk(clk), .i_n_rst(rst_n), .i_w_data_en(wen), .i_w_tlp_data(wdata),
    .i_w_commit(commit), .i_w_abort(abort), .o_w_full(full), .o_w_free_lines(free),
    .i_r_start(start), .i_r_lines(lines), .o_r_busy(busy), .o_r_empty(empty),
    .o_r_valid(valid), .o_r_data(rdata), .o_r_last(last), .i_r_ready(ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [255:0] a, input logic [255:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  // model: lines still in the buffer split into committed and pending
  logic [255:0] mq_c[$], mq_p[$], acc_d[$];
  bit           acc_l[$];
  bit           m_act, m_v, m_l;
  int           m_rem;
  logic [255:0] m_d;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq_c.delete(); mq_p.delete();
      m_act = 0; m_rem = 0; m_v = 0; m_l = 0; m_d = '0;
    end else begin : upd
      int used;
      used = mq_c.size() + mq_p.size();
      if (!m_act) begin
        if (start && lines != 0) begin m_act = 1; m_rem = lines; end
      end else if (m_rem > 0 && mq_c.size() > 0 && (!m_v || ready)) begin
        m_d = mq_c.pop_front(); m_v = 1; m_l = (m_rem == 1); m_rem--;
      end else if (m_v && ready) begin
        if (m_l) m_act = 0;
        m_v = 0; m_l = 0;
      end
      if (abort) mq_p.delete();
      else begin
        if (wen && used < 256) mq_p.push_back(wdata);
        if (commit) begin
          foreach (mq_p[i]) mq_c.push_back(mq_p[i]);
          mq_p.delete();
        end
      end
    end
  end

  always @(negedge clk) if (rst_n) begin : cmp
    int used;
    used = mq_c.size() + mq_p.size();
    chk("valid", valid, m_v);
    chk("last", last, m_l);
    chk("busy", busy, m_act);
    chk("empty", empty, mq_c.size() == 0);
    chk("full", full, used == 256);
    chk("free", free, 256 - used);
    if (m_v) chk("data", rdata, m_d);
    if (valid && ready) begin acc_d.push_back(rdata); acc_l.push_back(last); end
  end

  always @(posedge clk) if (tog) #1 ready = ~ready;

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic wr(input logic [255:0] d, input bit c);
    wen = 1; wdata = d; commit = c; tick(); wen = 0; commit = 0;
  endtask
  task automatic go(input int n);
    start = 1; lines = 8'(n); tick(); start = 0;
  endtask
  task automatic drain(input int n);
    int b = 0;
    while (acc_d.size() < n && b < 3000) begin tick(); b++; end
    chk("drain_count", acc_d.size(), n);
  endtask
  task automatic clr(); acc_d.delete(); acc_l.delete(); endtask
  function automatic logic [255:0] pat(input int i);
    return {8{32'hA5A5_0000 ^ 32'(i)}};
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("rst_free", free, 9'd256); chk("rst_empty", empty, 1'b1);
    chk("rst_valid", valid, 1'b0); chk("rst_data", rdata, '0);
    chk("rst_full", full, 1'b0); chk("rst_busy", busy, 1'b0);
    repeat (5) tick();
    chk("idle_nothing", acc_d.size(), 0);
    // A,B,C back to back
    tick();
    wr(256'hA, 0); wr(256'hB, 0); wr(256'hC, 1);
    go(3);
    repeat (3) tick();
    @(negedge clk);
    chk("abc_last", last, 1'b1); chk("abc_c", rdata, 256'hC);
    tick();
    @(negedge clk);
    chk("abc_busy", busy, 1'b0); chk("abc_free", free, 9'd256);
    chk("abc_n", acc_d.size(), 3);
    if (acc_d.size() == 3) begin
      chk("abc_0", acc_d[0], 256'hA); chk("abc_1", acc_d[1], 256'hB);
      chk("abc_l", {acc_l[0], acc_l[1], acc_l[2]}, 3'b001);
    end
    // abort rollback
    clr(); tick();
    wr(256'h11, 0); wr(256'h22, 0);
    @(negedge clk); chk("ab_free254", free, 9'd254);
    tick(); abort = 1; tick(); abort = 0;
    @(negedge clk); chk("ab_free256", free, 9'd256);
    tick(); wr(256'hDEAD, 1); go(1); drain(1);
    if (acc_d.size() == 1) begin chk("ab_x", acc_d[0], 256'hDEAD); chk("ab_xl", acc_l[0], 1'b1); end
    // fill to full, read back across the wrap with ready toggling
    clr(); tick();
    for (int i = 0; i < 256; i++) wr(pat(i), i == 255);
    @(negedge clk); chk("fill_full", full, 1'b1); chk("fill_free", free, 9'd0);
    tick(); wr(256'hBAD, 1);
    @(negedge clk); chk("drop_free", free, 9'd0);
    tick(); tog = 1; go(255); drain(255); go(1); drain(256); tog = 0;
    tick(); ready = 1;
    chk("wrap_n", acc_d.size(), 256);
    for (int i = 0; i < acc_d.size(); i++) chk("wrap_data", acc_d[i], pat(i));
    @(negedge clk); chk("wrap_empty", empty, 1'b1);
    // stall mid-TLP
    clr(); tick();
    wr(256'h1, 0); wr(256'h2, 1); go(4);
    repeat (6) tick();
    @(negedge clk);
    chk("stall_n", acc_d.size(), 2); chk("stall_valid", valid, 1'b0); chk("stall_busy", busy, 1'b1);
    tick(); wr(256'h3, 0); wr(256'h4, 1); drain(4);
    if (acc_d.size() == 4) begin
      chk("stall_d3", acc_d[3], 256'h4);
      chk("stall_l", {acc_l[0], acc_l[1], acc_l[2], acc_l[3]}, 4'b0001);
    end
    // write+commit+abort together
    clr(); tick(); tick();
    wr(256'h77, 0);
    wen = 1; commit = 1; abort = 1; tick(); wen = 0; commit = 0; abort = 0;
    @(negedge clk); chk("wca_free", free, 9'd256); chk("wca_empty", empty, 1'b1);
    // randomized traffic
    tick();
    for (int c = 0; c < 3000; c++) begin
      wen = $urandom_range(0, 99) < 60; wdata = {8{$urandom()}};
      commit = $urandom_range(0, 9) < 3; abort = $urandom_range(0, 49) == 0;
      ready = $urandom_range(0, 3) != 0; start = $urandom_range(0, 4) == 0;
      lines = 8'($urandom_range(0, 12));
      tick();
    end
    wen = 0; commit = 0; abort = 0; start = 0; ready = 1;
    rst_n = 0; tick(); rst_n = 1; tick();
    // asynchronous reset in the middle of a transfer
    clr();
    wr(256'h5, 0); wr(256'h6, 0); wr(256'h7, 1); go(3); tick();
    #2 rst_n = 0; #1;
    chk("mrst_valid", valid, 1'b0); chk("mrst_last", last, 1'b0); chk("mrst_data", rdata, '0);
    chk("mrst_busy", busy, 1'b0); chk("mrst_empty", empty, 1'b1); chk("mrst_free", free, 9'd256);
    tick(); rst_n = 1; repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
